// File: rtl/text_pkg.sv
// text_pkg -- shared constants and types for the text rendering path.
//
// Holds the font cell geometry, colour width, the printable-range bounds of
// the character set and the per-pixel control bundle that travels alongside
// the font ROM read in the glyph renderer pipeline.
package text_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam int COLOR_W = 12;

    localparam logic [6:0] ASCII_SPACE = 7'h20;
    localparam logic [6:0] ASCII_DEL   = 7'h7F;

    localparam int ASCII_W = 7;
    localparam int POS_W   = 10;
    localparam int COL_W   = $clog2(GLYPH_W);
    localparam int ROW_W   = $clog2(GLYPH_H);
    localparam int ROM_AW  = ASCII_W + ROW_W;

    // Everything about a pixel except the glyph bits themselves; it rides
    // beside the ROM read so it lines up with the data in the final stage.
    typedef struct packed {
        logic [COL_W-1:0]   col;
        logic               blank;
        logic               disp;
        logic               video;
        logic               hide;
        logic [COLOR_W-1:0] fg;
        logic [COLOR_W-1:0] bg;
    } pix_ctrl_t;

    // Control codes and DEL have no visible glyph.
    function automatic logic is_blank_code(input logic [ASCII_W-1:0] code);
        return (code < ASCII_SPACE) || (code == ASCII_DEL);
    endfunction

endpackage

// File: rtl/font_rom_8x16.sv
// font_rom_8x16 -- 2048 x 8 character generator ROM, one-cycle synchronous read.
//
// Ports:
//   clk   in   read clock
//   addr  in   11-bit address {ascii[6:0], row[3:0]}
//   data  out  8-bit glyph row, bit 7 = leftmost column, valid one edge after addr
//
// Content: space is blank, 'A' is the classic 8x16 VGA shape, every other
// code holds a hollow 8x16 box outline as a stand-in shape (control codes
// included; the renderer blanks those itself).
module font_rom_8x16
    import text_pkg::*;
(
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr,
    output logic [GLYPH_W-1:0] data
);

    function automatic logic [GLYPH_W-1:0] glyph_row(
        input logic [ASCII_W-1:0] code,
        input logic [ROW_W-1:0]   row
    );
        logic [GLYPH_W-1:0] bits;
        if (code == ASCII_SPACE) begin
            bits = 8'h00;
        end else if (code == 7'h41) begin
            case (row)
                4'd2:    bits = 8'h10;
                4'd3:    bits = 8'h38;
                4'd4:    bits = 8'h6C;
                4'd5,
                4'd6,
                4'd8,
                4'd9,
                4'd10,
                4'd11:   bits = 8'hC6;
                4'd7:    bits = 8'hFE;
                default: bits = 8'h00;
            endcase
        end else if (row == 4'd0 || row == 4'(GLYPH_H - 1)) begin
            bits = 8'hFF;
        end else begin
            bits = 8'h81;
        end
        return bits;
    endfunction

    // NOTE: ROM/RAM storage gets no reset -- it would stop the tools mapping
    // it onto block memory and buys nothing, since content is fixed.
    always_ff @(posedge clk) begin
        data <= glyph_row(addr[ROM_AW-1:ROW_W], addr[ROW_W-1:0]);
    end

endmodule

// File: rtl/glyph_renderer.sv
// glyph_renderer -- turns a character code and scan position into a pixel colour.
//
// Three-stage pipeline, one pixel per cycle, no stalls:
//   S0  register inputs, cell column/row offsets and the blink state
//   S1  synchronous font ROM read at {ascii, row}
//   S2  pick the glyph bit for the column and mux fg/bg/black
// Output for inputs sampled at edge k is visible after edge k+2.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   ascii_in              character code for the current box
//   display_contents      scan position is inside the character box
//   x, y                  current scan position
//   x_desired, y_desired  top-left corner of the character box
//   video_on              active display region
//   frame_start           one-cycle pulse per frame (advances blink counter)
//   blink_en              enable blinking
//   fg_color, bg_color    RGB444 colours
//   rgb                   registered pixel colour
//   pixel_valid           registered, video_on delayed two cycles
module glyph_renderer
    import text_pkg::*;
#(
    parameter int SCALE     = 2,
    parameter int BLINK_BIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ASCII_W-1:0]   ascii_in,
    input  logic                 display_contents,
    input  logic [POS_W-1:0]     x,
    input  logic [POS_W-1:0]     y,
    input  logic [POS_W-1:0]     x_desired,
    input  logic [POS_W-1:0]     y_desired,
    input  logic                 video_on,
    input  logic                 frame_start,
    input  logic                 blink_en,
    input  logic [COLOR_W-1:0]   fg_color,
    input  logic [COLOR_W-1:0]   bg_color,
    output logic [COLOR_W-1:0]   rgb,
    output logic                 pixel_valid
);

    localparam logic [POS_W-1:0] SCALE_V = POS_W'(SCALE);

    // ---------------------------------------------------------------
    // Offsets into the character cell. Subtraction wraps modulo 1024 and
    // the quotient is truncated to the cell size, so a position left of or
    // above the box simply lands on some cell column/row.
    // ---------------------------------------------------------------
    logic [POS_W-1:0] dx, dy, col_full, row_full;

    assign dx       = x - x_desired;
    assign dy       = y - y_desired;
    assign col_full = dx / SCALE_V;
    assign row_full = dy / SCALE_V;

    // ---------------------------------------------------------------
    // Blink frame counter
    // ---------------------------------------------------------------
    logic [5:0] frame_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, as real flops do.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 6'd1;
        end
    end

    // ---------------------------------------------------------------
    // S0: input register. The blink bit is captured here, so a frame_start
    // on the same edge only affects pixels sampled afterwards.
    // ---------------------------------------------------------------
    pix_ctrl_t          s0_ctrl;
    logic [ASCII_W-1:0] s0_ascii;
    logic [ROW_W-1:0]   s0_row;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_ctrl  <= '0;
            s0_ascii <= '0;
            s0_row   <= '0;
        end else begin
            s0_ctrl.col   <= col_full[COL_W-1:0];
            s0_ctrl.blank <= is_blank_code(ascii_in);
            s0_ctrl.disp  <= display_contents;
            s0_ctrl.video <= video_on;
            s0_ctrl.hide  <= blink_en & frame_cnt[BLINK_BIT];
            s0_ctrl.fg    <= fg_color;
            s0_ctrl.bg    <= bg_color;
            s0_ascii      <= ascii_in;
            s0_row        <= row_full[ROW_W-1:0];
        end
    end

    // ---------------------------------------------------------------
    // S1: font ROM read, control bundle delayed alongside it
    // ---------------------------------------------------------------
    logic [GLYPH_W-1:0] rom_data;
    pix_ctrl_t          s1_ctrl;

    font_rom_8x16 u_font_rom (
        .clk  (clk),
        .addr ({s0_ascii, s0_row}),
        .data (rom_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_ctrl <= '0;
        end else begin
            s1_ctrl <= s0_ctrl;
        end
    end

    // ---------------------------------------------------------------
    // S2: bit select and colour mux
    // ---------------------------------------------------------------
    logic               glyph_on;
    logic [COLOR_W-1:0] rgb_next;

    // Bit 7 is the leftmost column, so column c reads bit (7 - c).
    assign glyph_on = rom_data[COL_W'(GLYPH_W - 1) - s1_ctrl.col]
                      & ~s1_ctrl.blank & s1_ctrl.disp & ~s1_ctrl.hide;

    // NOTE: a default assignment first keeps this purely combinational;
    // any path that left rgb_next unassigned would infer a latch.
    always_comb begin
        rgb_next = '0;
        if (s1_ctrl.video) begin
            rgb_next = glyph_on ? s1_ctrl.fg : s1_ctrl.bg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb         <= '0;
            pixel_valid <= 1'b0;
        end else begin
            rgb         <= rgb_next;
            pixel_valid <= s1_ctrl.video;
        end
    end

endmodule
